// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes.
module muldiv_unit #(
   parameter int XLEN         = 32,
   parameter bit FAST_SPECIAL = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] Result,
   output logic            Zero
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t r_state;
   state_t w_next;

   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_b;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [2:0]      r_op;
   logic            r_neg;
   logic            r_spec;
   logic [XLEN-1:0] r_spec_val;

   logic            w_sgn_a;
   logic            w_sgn_b;
   logic            w_neg_a;
   logic            w_neg_b;
   logic [XLEN-1:0] w_mag_a;
   logic [XLEN-1:0] w_mag_b;
   logic            w_bzero;
   logic            w_ovf;
   logic            w_spec;
   logic [XLEN-1:0] w_spec_val;
   logic            w_accept;

   logic [XLEN:0]     w_sum;
   logic [XLEN:0]     w_rsh;
   logic [XLEN:0]     w_rsub;
   logic              w_ge;
   logic [XLEN-1:0]   w_hi_n;
   logic [XLEN-1:0]   w_lo_n;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_res_run;
   logic [XLEN-1:0]   w_res_fin;

   // Operand decode on the raw inputs, used only at capture time
   assign w_sgn_a    = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
   assign w_sgn_b    = funct3[2] ? ~funct3[0] : ~funct3[1];
   assign w_neg_a    = w_sgn_a & A[XLEN-1];
   assign w_neg_b    = w_sgn_b & B[XLEN-1];
   assign w_mag_a    = w_neg_a ? -A : A;
   assign w_mag_b    = w_neg_b ? -B : B;
   assign w_bzero    = (B == '0);
   assign w_ovf      = ~funct3[0] & (A == MIN_NEG) & (&B);
   assign w_spec     = funct3[2] & (w_bzero | w_ovf);
   assign w_spec_val = w_bzero ? (funct3[1] ? A : '1)
                               : (funct3[1] ? '0 : A);
   assign w_accept   = (r_state == S_IDLE) & start & ~flush;

   // One iteration step for both datapaths
   assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
   assign w_rsh  = {r_hi, r_lo[XLEN-1]};
   assign w_rsub = w_rsh - {1'b0, r_b};
   assign w_ge   = (w_rsh >= {1'b0, r_b});

   always_comb begin
      w_hi_n = r_hi;
      w_lo_n = r_lo;
      if (r_op[2]) begin
         w_hi_n = w_ge ? w_rsub[XLEN-1:0] : w_rsh[XLEN-1:0];
         w_lo_n = {r_lo[XLEN-2:0], w_ge};
      end else begin
         w_hi_n = w_sum[XLEN:1];
         w_lo_n = {w_sum[0], r_lo[XLEN-1:1]};
      end
   end

   assign w_prod = r_neg ? -{w_hi_n, w_lo_n} : {w_hi_n, w_lo_n};
   assign w_quo  = r_neg ? -w_lo_n : w_lo_n;
   assign w_rem  = r_neg ? -w_hi_n : w_hi_n;

   always_comb begin
      w_res_run = '0;
      if (r_spec) begin
         w_res_run = r_spec_val;
      end else begin
         unique case (r_op)
            3'b000:                 w_res_run = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_res_run = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_res_run = w_quo;
            default:                w_res_run = w_rem;
         endcase
      end
   end

   // Fast special cases finish straight from IDLE using the raw inputs
   assign w_res_fin = (r_state == S_IDLE) ? w_spec_val : w_res_run;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept)
               w_next = (FAST_SPECIAL && w_spec) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (flush)
               w_next = S_IDLE;
            else if (r_cnt == CW'(XLEN-1))
               w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == S_RUN);
      done = (r_state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt      <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_op       <= '0;
         r_neg      <= 1'b0;
         r_spec     <= 1'b0;
         r_spec_val <= '0;
         Result     <= '0;
         Zero       <= 1'b1;
      end else begin
         if (w_accept) begin
            r_cnt      <= '0;
            r_a        <= w_mag_a;
            r_b        <= w_mag_b;
            r_hi       <= '0;
            r_lo       <= funct3[2] ? w_mag_a : w_mag_b;
            r_op       <= funct3;
            r_neg      <= (funct3[2] & funct3[1]) ? w_neg_a
                                                  : (w_neg_a ^ w_neg_b);
            r_spec     <= w_spec;
            r_spec_val <= w_spec_val;
         end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 1'b1;
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
         end
         if (w_next == S_DONE) begin
            Result <= w_res_fin;
            Zero   <= (w_res_fin == '0);
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: 32-bit fast/slow special-case builds
// sharing stimulus, plus a 64-bit build.
module tb_muldiv_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start;
   logic        flush;
   logic [2:0]  funct3;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy_f, done_f, zero_f;
   logic [31:0] res_f;
   logic        busy_s, done_s, zero_s;
   logic [31:0] res_s;

   logic        start64;
   logic [2:0]  f3_64;
   logic [63:0] a64;
   logic [63:0] b64;
   logic        busy64, done64, zero64;
   logic [63:0] res64;

   int n_chk  = 0;
   int n_fail = 0;

   logic [64:0] q_f[$];
   logic [64:0] q_s[$];
   logic [64:0] q_64[$];

   muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut_f (
      .clk(clk), .reset(reset), .start(start), .funct3(funct3),
      .A(a), .B(b), .flush(flush), .busy(busy_f), .done(done_f),
      .Result(res_f), .Zero(zero_f)
   );

   muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b0)) dut_s (
      .clk(clk), .reset(reset), .start(start), .funct3(funct3),
      .A(a), .B(b), .flush(flush), .busy(busy_s), .done(done_s),
      .Result(res_s), .Zero(zero_s)
   );

   muldiv_unit #(.XLEN(64), .FAST_SPECIAL(1'b1)) dut_64 (
      .clk(clk), .reset(reset), .start(start64), .funct3(f3_64),
      .A(a64), .B(b64), .flush(1'b0), .busy(busy64), .done(done64),
      .Result(res64), .Zero(zero64)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref32(input logic [2:0] f,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
      longint      sx, sy, uy;
      logic [63:0] p;
      logic        ovf;
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      uy  = longint'({32'b0, y});
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      p   = '0;
      case (f)
         3'd0: begin p = sx * sy; return p[31:0]; end
         3'd1: begin p = sx * sy; return p[63:32]; end
         3'd2: begin p = sx * uy; return p[63:32]; end
         3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
         3'd4: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (ovf) return x;
            p = sx / sy; return p[31:0];
         end
         3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: begin
            if (y == 0) return x;
            if (ovf) return 32'd0;
            p = sx % sy; return p[31:0];
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic logic spec32(input logic [2:0] f,
                                   input logic [31:0] x,
                                   input logic [31:0] y);
      return f[2] && ((y == 0) ||
             (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
   endfunction

   always @(negedge clk) begin
      if (done_f) begin
         chk("f_sb_pending", 64'(q_f.size() > 0), 64'd1);
         if (q_f.size() > 0) begin
            logic [64:0] e;
            e = q_f.pop_front();
            chk("f_result", 64'(res_f), e[63:0]);
            chk("f_zero", 64'(zero_f), 64'(e[64]));
         end
      end
      if (done_s) begin
         chk("s_sb_pending", 64'(q_s.size() > 0), 64'd1);
         if (q_s.size() > 0) begin
            logic [64:0] e;
            e = q_s.pop_front();
            chk("s_result", 64'(res_s), e[63:0]);
            chk("s_zero", 64'(zero_s), 64'(e[64]));
         end
      end
      if (done64) begin
         chk("x_sb_pending", 64'(q_64.size() > 0), 64'd1);
         if (q_64.size() > 0) begin
            logic [64:0] e;
            e = q_64.pop_front();
            chk("x_result", res64, e[63:0]);
            chk("x_zero", 64'(zero64), 64'(e[64]));
         end
      end
   end

   // Cycle c is the cycle that follows clock edge c-1 (start sampled at edge 0)
   task automatic op(input logic [2:0] f, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp);
      int lf = 0, ls = 0, bf = 0, bs = 0, c = 1;
      int lat_f;
      lat_f = spec32(f, x, y) ? 1 : 33;
      q_f.push_back({exp == 0, 32'b0, exp});
      q_s.push_back({exp == 0, 32'b0, exp});
      funct3 = f; a = x; b = y; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      while (c <= 100) begin
         if (busy_f) bf++;
         if (busy_s) bs++;
         if (done_f && lf == 0) lf = c;
         if (done_s && ls == 0) ls = c;
         if (lf != 0 && ls != 0) break;
         @(posedge clk); #1 c++;
      end
      chk("f_latency", 64'(lf), 64'(lat_f));
      chk("s_latency", 64'(ls), 64'd33);
      chk("f_busy_cycles", 64'(bf), 64'(lat_f - 1));
      chk("s_busy_cycles", 64'(bs), 64'd32);
      @(posedge clk); #1;
   endtask

   task automatic op64(input logic [2:0] f, input logic [63:0] x,
                       input logic [63:0] y, input logic [63:0] exp,
                       input int lat);
      int l = 0, c = 1;
      q_64.push_back({exp == 0, exp});
      f3_64 = f; a64 = x; b64 = y; start64 = 1'b1;
      @(posedge clk); #1 start64 = 1'b0;
      while (c <= 200 && l == 0) begin
         if (done64) l = c;
         else begin @(posedge clk); #1 c++; end
      end
      chk("x_latency", 64'(l), 64'(lat));
      @(posedge clk); #1;
   endtask

   initial begin
      int nd;
      logic [31:0] x, y;
      logic [2:0]  f;
      reset = 1'b1; start = 1'b0; flush = 1'b0;
      funct3 = '0; a = '0; b = '0;
      start64 = 1'b0; f3_64 = '0; a64 = '0; b64 = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_busy", 64'(busy_f), 64'd0);
      chk("rst_done", 64'(done_s), 64'd0);
      chk("rst_result", 64'(res_f), 64'd0);
      chk("rst_zero", 64'(zero_f), 64'd1);
      chk("rst_zero64", 64'(zero64), 64'd1);

      op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
      op(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
      op(3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
      op(3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF);
      op(3'd5, 32'd100,        32'd7,         32'd14);
      op(3'd7, 32'd100,        32'd7,         32'd2);
      op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
      op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
      op(3'd4, 32'd5,          32'd5,         32'd1);
      op(3'd6, 32'd5,          32'd5,         32'd0);
      op(3'd4, 32'd42,         32'd0,         32'hFFFF_FFFF);
      op(3'd7, 32'd42,         32'd0,         32'd42);
      op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
      op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);

      for (int i = 0; i < 24; i++) begin
         f = 3'($urandom_range(0, 7));
         x = $urandom;
         y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if (i % 4 == 1) y = 32'($urandom_range(1, 300));
         op(f, x, y, ref32(f, x, y));
      end

      // Restarts while busy and while in DONE are ignored
      q_f.push_back({1'b0, 32'b0, 32'd12});
      q_s.push_back({1'b0, 32'b0, 32'd12});
      funct3 = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      nd = 0;
      for (int c = 1; c <= 40; c++) begin
         if (done_f) nd++;
         if (c == 33) chk("restart_done_c33", 64'(done_f), 64'd1);
         if (c == 35) chk("restart_busy_c35", 64'(busy_f), 64'd0);
         start = (c == 5 || c == 33);
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("restart_done_count", 64'(nd), 64'd1);

      // Flush in RUN aborts without done
      funct3 = 3'd5; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      nd = 0;
      for (int c = 1; c <= 40; c++) begin
         if (done_f || done_s) nd++;
         if (c == 10) chk("flush_busy_c10", 64'(busy_f), 64'd1);
         if (c == 11) begin
            chk("flush_busy_f_c11", 64'(busy_f), 64'd0);
            chk("flush_busy_s_c11", 64'(busy_s), 64'd0);
         end
         flush = (c == 10);
         @(posedge clk); #1;
      end
      flush = 1'b0;
      chk("flush_no_done", 64'(nd), 64'd0);
      chk("flush_result_kept", 64'(res_f), 64'd12);

      // start together with flush in IDLE is ignored
      funct3 = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1 start = 1'b0; flush = 1'b0;
      chk("startflush_busy", 64'(busy_s), 64'd0);
      chk("startflush_done", 64'(done_f), 64'd0);
      repeat (2) @(posedge clk);
      #1;

      // Reset in the middle of a divide
      funct3 = 3'd5; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c < 15; c++) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      chk("midrst_busy", 64'(busy_f), 64'd0);
      chk("midrst_done", 64'(done_s), 64'd0);
      chk("midrst_result", 64'(res_f), 64'd0);
      chk("midrst_zero", 64'(zero_s), 64'd1);
      repeat (2) @(posedge clk);
      #1;

      op64(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 65);
      op64(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 65);
      op64(3'd5, 64'd77, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      op64(3'd0, 64'd123456789, 64'd1000, 64'd123456789000, 65);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_f_empty", 64'(q_f.size()), 64'd0);
      chk("sb_s_empty", 64'(q_s.size()), 64'd0);
      chk("sb_64_empty", 64'(q_64.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
